// File: rtl/regfile_ctrl_pkg.sv
// Common types for the register-file controller, built on the shared encoding header.
package regfile_ctrl_pkg;

`include "regfile_defs.vh"

    typedef enum logic {
        ST_CLEAR = `RF_STATE_CLEAR,
        ST_RUN   = `RF_STATE_RUN
    } state_e;

    localparam logic PORT_A = `RF_PORT_A;
    localparam logic PORT_B = `RF_PORT_B;

endpackage

// File: rtl/regfile_defs.vh
// Shared encodings for the register-file controller: FSM states and write-port ids.
`ifndef REGFILE_DEFS_VH
`define REGFILE_DEFS_VH

`define RF_STATE_CLEAR 1'b0
`define RF_STATE_RUN   1'b1
`define RF_PORT_A      1'b0
`define RF_PORT_B      1'b1

`endif

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; on contention the port not granted last wins.
module rr_arb2
    import regfile_ctrl_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req[0] && (!req[1] || last == PORT_B)) begin
            gnt[0] = 1'b1;
        end else if (req[1]) begin
            gnt[1] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_ctrl.sv
// Register-file front end: zeroing sweep, arbitrated core/debug writes and a
// bypassed debug read port in front of an external storage array.
module regfile_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr_req,
    input  logic                  a_wreq,
    input  logic [ADDR_WIDTH-1:0] a_waddr,
    input  logic [WIDTH-1:0]      a_wdata,
    output logic                  a_wgnt,
    input  logic                  b_wreq,
    input  logic [ADDR_WIDTH-1:0] b_waddr,
    input  logic [WIDTH-1:0]      b_wdata,
    output logic                  b_wgnt,
    input  logic                  b_rreq,
    input  logic [ADDR_WIDTH-1:0] b_raddr,
    output logic                  b_rvalid,
    output logic [WIDTH-1:0]      b_rdata,
    output logic                  rf_we,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [WIDTH-1:0]      rf_wdata,
    output logic [ADDR_WIDTH-1:0] rf_raddr,
    input  logic [WIDTH-1:0]      rf_rdata,
    output logic                  busy
);

    localparam int                  N        = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CNT_LAST = (ADDR_WIDTH + 1)'(N - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic                  last_q, last_d;
    logic                  rf_we_q, rf_we_d;
    logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
    logic [WIDTH-1:0]      rf_wdata_q, rf_wdata_d;
    logic                  b_rvalid_q, b_rvalid_d;
    logic [WIDTH-1:0]      b_rdata_q, b_rdata_d;

    logic [1:0]            arb_gnt;
    logic                  run;
    logic                  grant_ok;
    logic [WIDTH-1:0]      rd_value;

    rr_arb2 u_arb (
        .req  ({b_wreq, a_wreq}),
        .last (last_q),
        .gnt  (arb_gnt)
    );

    assign run      = (state_q == ST_RUN);
    assign grant_ok = run && !clr_req;
    assign a_wgnt   = grant_ok && arb_gnt[0];
    assign b_wgnt   = grant_ok && arb_gnt[1];
    assign busy     = !run;
    assign rf_raddr = b_raddr;

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign b_rvalid = b_rvalid_q;
    assign b_rdata  = b_rdata_q;

    // Register 0 reads as zero; a write still on its way to storage wins over the array.
    always_comb begin
        rd_value = rf_rdata;
        if (b_raddr == '0) begin
            rd_value = '0;
        end else if (rf_we_q && rf_waddr_q == b_raddr) begin
            rd_value = rf_wdata_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        b_rvalid_d = 1'b0;
        b_rdata_d  = b_rdata_q;

        case (state_q)
            ST_CLEAR: begin
                rf_we_d    = 1'b1;
                rf_waddr_d = cnt_q[ADDR_WIDTH-1:0];
                rf_wdata_d = '0;
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                if (a_wgnt) begin
                    rf_we_d    = (a_waddr != '0);
                    rf_waddr_d = a_waddr;
                    rf_wdata_d = a_wdata;
                    last_d     = PORT_A;
                end else if (b_wgnt) begin
                    rf_we_d    = (b_waddr != '0);
                    rf_waddr_d = b_waddr;
                    rf_wdata_d = b_wdata;
                    last_d     = PORT_B;
                end
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
                if (b_rreq) begin
                    b_rvalid_d = 1'b1;
                    b_rdata_d  = rd_value;
                end
            end
        endcase
    end

    // Reset parks the pointer on B so that A wins the first contended cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_CLEAR;
            cnt_q      <= '0;
            last_q     <= PORT_B;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            b_rvalid_q <= 1'b0;
            b_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            b_rvalid_q <= b_rvalid_d;
            b_rdata_q  <= b_rdata_d;
        end
    end

endmodule

// File: tb/tb_regfile_ctrl.sv
// Directed bench for regfile_ctrl: sweep, arbitration, zero register, bypass, clear and reset.
module tb_regfile_ctrl;

    localparam int WIDTH = 32;
    localparam int AW    = 5;

    logic             clk;
    logic             reset;
    logic             clr_req;
    logic             a_wreq;
    logic [AW-1:0]    a_waddr;
    logic [WIDTH-1:0] a_wdata;
    logic             a_wgnt;
    logic             b_wreq;
    logic [AW-1:0]    b_waddr;
    logic [WIDTH-1:0] b_wdata;
    logic             b_wgnt;
    logic             b_rreq;
    logic [AW-1:0]    b_raddr;
    logic             b_rvalid;
    logic [WIDTH-1:0] b_rdata;
    logic             rf_we;
    logic [AW-1:0]    rf_waddr;
    logic [WIDTH-1:0] rf_wdata;
    logic [AW-1:0]    rf_raddr;
    logic [WIDTH-1:0] rf_rdata;
    logic             busy;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_ctrl #(
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .clr_req  (clr_req),
        .a_wreq   (a_wreq),
        .a_waddr  (a_waddr),
        .a_wdata  (a_wdata),
        .a_wgnt   (a_wgnt),
        .b_wreq   (b_wreq),
        .b_waddr  (b_waddr),
        .b_wdata  (b_wdata),
        .b_wgnt   (b_wgnt),
        .b_rreq   (b_rreq),
        .b_raddr  (b_raddr),
        .b_rvalid (b_rvalid),
        .b_rdata  (b_rdata),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .rf_raddr (rf_raddr),
        .rf_rdata (rf_rdata),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One sweep cycle per iteration: grants blocked before the edge, zero write after it.
    task automatic sweep_steps(input int count, input int clr_at);
        for (int i = 0; i < count; i++) begin
            clr_req = (i == clr_at);
            #1;
            chk($sformatf("sweep_busy[%0d]", i), 32'(busy), 32'd1);
            chk($sformatf("sweep_agnt[%0d]", i), 32'(a_wgnt), 32'd0);
            chk($sformatf("sweep_bgnt[%0d]", i), 32'(b_wgnt), 32'd0);
            step();
            clr_req = 1'b0;
            chk($sformatf("sweep_we[%0d]", i), 32'(rf_we), 32'd1);
            chk($sformatf("sweep_addr[%0d]", i), 32'(rf_waddr), 32'(i));
            chk($sformatf("sweep_data[%0d]", i), rf_wdata, 32'd0);
            chk($sformatf("sweep_rvalid[%0d]", i), 32'(b_rvalid), 32'd0);
            $display("[TB] sweep cycle %0d: rf_we=%0b rf_waddr=%0d", i, rf_we, rf_waddr);
        end
    endtask

    initial begin
        reset    = 1'b1;
        clr_req  = 1'b0;
        a_wreq   = 1'b0;
        a_waddr  = '0;
        a_wdata  = '0;
        b_wreq   = 1'b0;
        b_waddr  = '0;
        b_wdata  = '0;
        b_rreq   = 1'b0;
        b_raddr  = '0;
        rf_rdata = '0;
        #1;
        reset = 1'b0;

        // Requests held through reset and the first sweep; they must not be served early.
        a_wreq   = 1'b1; a_waddr = 5'd1; a_wdata = 32'hAAAA_0001;
        b_wreq   = 1'b1; b_waddr = 5'd2; b_wdata = 32'hBBBB_0002;
        b_rreq   = 1'b1; b_raddr = 5'd9; rf_rdata = 32'hCAFE_F00D;
        #1;
        chk("rst_busy",   32'(busy),     32'd1);
        chk("rst_we",     32'(rf_we),    32'd0);
        chk("rst_waddr",  32'(rf_waddr), 32'd0);
        chk("rst_wdata",  rf_wdata,      32'd0);
        chk("rst_rvalid", 32'(b_rvalid), 32'd0);
        chk("rst_rdata",  b_rdata,       32'd0);
        chk("rst_agnt",   32'(a_wgnt),   32'd0);
        chk("rst_bgnt",   32'(b_wgnt),   32'd0);
        $display("[TB] reset: busy=%0b rf_we=%0b", busy, rf_we);
        step();
        chk("rst_hold_we", 32'(rf_we), 32'd0);
        reset = 1'b1;

        sweep_steps(32, -1);
        b_rreq = 1'b0;
        chk("sweep_done_busy", 32'(busy), 32'd0);

        // Contention: A, B, A, B with pointer favouring A after reset.
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("rr_agnt[%0d]", k), 32'(a_wgnt), 32'(k % 2 == 0));
            chk($sformatf("rr_bgnt[%0d]", k), 32'(b_wgnt), 32'(k % 2 == 1));
            step();
            chk($sformatf("rr_we[%0d]", k), 32'(rf_we), 32'd1);
            chk($sformatf("rr_waddr[%0d]", k), 32'(rf_waddr), (k % 2 == 0) ? 32'd1 : 32'd2);
            chk($sformatf("rr_wdata[%0d]", k), rf_wdata,
                (k % 2 == 0) ? 32'hAAAA_0001 : 32'hBBBB_0002);
            $display("[TB] rr cycle %0d: rf_waddr=%0d rf_wdata=%h", k, rf_waddr, rf_wdata);
        end
        a_wreq = 1'b0;
        b_wreq = 1'b0;
        #1;
        step();
        chk("idle_we", 32'(rf_we), 32'd0);

        // Single core write.
        a_wreq = 1'b1; a_waddr = 5'd5; a_wdata = 32'hDEAD_BEEF;
        #1;
        chk("a_only_agnt", 32'(a_wgnt), 32'd1);
        chk("a_only_bgnt", 32'(b_wgnt), 32'd0);
        step();
        a_wreq = 1'b0;
        chk("a_only_we",    32'(rf_we),    32'd1);
        chk("a_only_waddr", 32'(rf_waddr), 32'd5);
        chk("a_only_wdata", rf_wdata,      32'hDEAD_BEEF);
        $display("[TB] core write: rf_waddr=%0d rf_wdata=%h", rf_waddr, rf_wdata);

        // Register 0 writes are acknowledged but dropped; reads return zero.
        a_wreq = 1'b1; a_waddr = 5'd0; a_wdata = 32'hFFFF_FFFF;
        #1;
        chk("zero_wr_agnt", 32'(a_wgnt), 32'd1);
        step();
        a_wreq = 1'b0;
        chk("zero_wr_we", 32'(rf_we), 32'd0);
        b_rreq = 1'b1; b_raddr = 5'd0; rf_rdata = 32'h5555_5555;
        #1;
        chk("zero_rd_raddr", 32'(rf_raddr), 32'd0);
        step();
        b_rreq = 1'b0;
        chk("zero_rd_valid", 32'(b_rvalid), 32'd1);
        chk("zero_rd_data",  b_rdata,       32'd0);
        #1;
        step();
        chk("rvalid_one_cycle", 32'(b_rvalid), 32'd0);
        $display("[TB] zero register: b_rdata=%h", b_rdata);

        // Plain read from storage.
        b_rreq = 1'b1; b_raddr = 5'd9; rf_rdata = 32'hCAFE_F00D;
        #1;
        chk("rd_raddr", 32'(rf_raddr), 32'd9);
        step();
        b_rreq = 1'b0;
        chk("rd_valid", 32'(b_rvalid), 32'd1);
        chk("rd_data",  b_rdata,       32'hCAFE_F00D);
        $display("[TB] read addr 9: b_rdata=%h", b_rdata);

        // Bypass read of addr 7 alongside a debug write to addr 10.
        a_wreq = 1'b1; a_waddr = 5'd7; a_wdata = 32'h1234_5678;
        #1;
        chk("byp_wr_agnt", 32'(a_wgnt), 32'd1);
        step();
        a_wreq = 1'b0;
        chk("byp_wr_addr", 32'(rf_waddr), 32'd7);
        b_rreq = 1'b1; b_raddr = 5'd7; rf_rdata = 32'd0;
        b_wreq = 1'b1; b_waddr = 5'd10; b_wdata = 32'h0BAD_C0DE;
        #1;
        chk("par_bgnt", 32'(b_wgnt), 32'd1);
        step();
        b_wreq = 1'b0;
        chk("byp_valid",  32'(b_rvalid), 32'd1);
        chk("byp_data",   b_rdata,       32'h1234_5678);
        chk("par_we",     32'(rf_we),    32'd1);
        chk("par_waddr",  32'(rf_waddr), 32'd10);
        chk("par_wdata",  rf_wdata,      32'h0BAD_C0DE);
        $display("[TB] bypass read: b_rdata=%h, parallel write addr %0d", b_rdata, rf_waddr);
        b_raddr = 5'd11; rf_rdata = 32'h1111_1111;
        #1;
        step();
        b_rreq = 1'b0;
        chk("nobyp_data", b_rdata, 32'h1111_1111);

        // Clear request with both writers pending, after a fresh grant.
        a_wreq = 1'b1; a_waddr = 5'd12; a_wdata = 32'h0C0C_0C0C;
        #1;
        chk("pre_clr_agnt", 32'(a_wgnt), 32'd1);
        step();
        a_wreq = 1'b1; a_waddr = 5'd3; a_wdata = 32'h0000_0003;
        b_wreq = 1'b1; b_waddr = 5'd4; b_wdata = 32'h0000_0004;
        clr_req = 1'b1;
        #1;
        chk("clr_agnt",  32'(a_wgnt),   32'd0);
        chk("clr_bgnt",  32'(b_wgnt),   32'd0);
        chk("clr_busy",  32'(busy),     32'd0);
        chk("clr_prior_we",    32'(rf_we),    32'd1);
        chk("clr_prior_waddr", 32'(rf_waddr), 32'd12);
        step();
        clr_req = 1'b0;
        chk("clr_enter_busy", 32'(busy),  32'd1);
        chk("clr_enter_we",   32'(rf_we), 32'd0);
        $display("[TB] clear entered: busy=%0b", busy);

        // Clear pulse at sweep cycle 10 must not restart the count.
        sweep_steps(20, 10);

        // Async reset mid-sweep, then a full sweep from 0.
        reset = 1'b0;
        #1;
        chk("midrst_busy",  32'(busy),     32'd1);
        chk("midrst_we",    32'(rf_we),    32'd0);
        chk("midrst_waddr", 32'(rf_waddr), 32'd0);
        reset = 1'b1;
        sweep_steps(32, -1);
        chk("resweep_done_busy", 32'(busy), 32'd0);

        // Pointer was reset to favour A.
        #1;
        chk("post_rst_agnt", 32'(a_wgnt), 32'd1);
        chk("post_rst_bgnt", 32'(b_wgnt), 32'd0);
        step();
        a_wreq = 1'b0;
        chk("post_rst_waddr_a", 32'(rf_waddr), 32'd3);
        chk("post_rst_wdata_a", rf_wdata,      32'h0000_0003);
        #1;
        chk("post_rst_bgnt2", 32'(b_wgnt), 32'd1);
        step();
        b_wreq = 1'b0;
        chk("post_rst_waddr_b", 32'(rf_waddr), 32'd4);
        $display("[TB] pending writes served after sweep: last rf_waddr=%0d", rf_waddr);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_ctrl.md
REGFILE_CTRL -- requirements
Module: regfile_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, data width of every write/read data port.
REQ-002 Parameter ADDR_WIDTH, default 5, register address width; register count N = 2**ADDR_WIDTH.
REQ-003 One clock; reset is asynchronous and active-low: clk  in  1  sole clock, all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-low; asserted (0) clears all state immediately.
REQ-005 clr_req  in  1  one-cycle pulse requesting a full zeroing sweep.
REQ-006 a_wreq / a_waddr / a_wdata  in  1 / ADDR_WIDTH / WIDTH  core write request, address, data.
REQ-007 a_wgnt  out  1  core write accepted this cycle (combinational).
REQ-008 b_wreq / b_waddr / b_wdata  in  1 / ADDR_WIDTH / WIDTH  debug write request, address, data.
REQ-009 b_wgnt  out  1  debug write accepted this cycle (combinational).
REQ-010 b_rreq / b_raddr  in  1 / ADDR_WIDTH  debug read request and address.
REQ-011 b_rvalid / b_rdata  out  1 / WIDTH  registered debug read response.
REQ-012 rf_we / rf_waddr / rf_wdata  out  1 / ADDR_WIDTH / WIDTH  registered write port to the storage array.
REQ-013 rf_raddr  out  ADDR_WIDTH  storage read address, combinationally equal to b_raddr.
REQ-014 rf_rdata  in  WIDTH  combinational storage read data for rf_raddr.
REQ-015 busy  out  1  high while a clear sweep is in progress, combinational from state.

Function
REQ-016 The block SHALL implement states CLEAR and RUN; CLEAR holds a sweep counter cnt (ADDR_WIDTH+1 bits).
REQ-017 In CLEAR, at each edge, the block SHALL register rf_we=1, rf_waddr=cnt, rf_wdata=0 and increment cnt; after the edge issuing address N-1 it SHALL enter RUN (N cycles total).
REQ-018 In CLEAR, a_wgnt, b_wgnt SHALL be 0 and b_rreq SHALL be ignored (no b_rvalid).
REQ-019 A write transfer occurs only when req and gnt are both high in the same cycle; requesters hold req, addr and data until granted.
REQ-020 In RUN with exactly one write requester, that requester SHALL be granted.
REQ-021 In RUN with both requesting, the requester not granted most recently SHALL be granted; the last-grant pointer updates on every grant and resets to favour A.
REQ-022 A granted write SHALL appear on rf_we/rf_waddr/rf_wdata at the next edge (1-cycle latency); rf_we SHALL be 0 in any cycle following no grant.
REQ-023 A granted write to address 0 SHALL be acknowledged but SHALL leave rf_we=0 (register 0 read-only zero).
REQ-024 In RUN, b_rreq SHALL produce b_rvalid=1 for exactly one cycle at the next edge with b_rdata captured at that edge.
REQ-025 Read bypass: if rf_we=1 and rf_waddr==b_raddr when sampled, b_rdata SHALL take rf_wdata instead of rf_rdata; b_raddr==0 SHALL return 0.
REQ-026 clr_req in RUN SHALL suppress both grants that cycle and enter CLEAR with cnt=0 at the next edge; the write registered on that edge from the prior cycle's grant SHALL still be issued.
REQ-027 clr_req while in CLEAR SHALL be ignored; the sweep SHALL not restart.
REQ-028 Reads and writes SHALL be independent: one debug read and one write may complete in the same cycle.

Reset
REQ-029 On reset=0: state=CLEAR, cnt=0, last-grant pointer=B (A favoured), rf_we=0, rf_waddr=0, rf_wdata=0, b_rvalid=0, b_rdata=0; busy=1, grants=0.
REQ-030 On reset release the sweep SHALL start automatically; reset asserted mid-sweep or mid-transfer SHALL abort it and restart the sweep from address 0.

Structure
REQ-031 State encodings and port-id constants (PORT_A, PORT_B) SHALL live in a shared include header regfile_defs.vh guarded by `ifndef.
REQ-032 Two-way arbitration SHALL be a sub-module rr_arb2 (req[1:0], last pointer in, gnt[1:0] out, combinational); all sequencing stays in regfile_ctrl.

Verification
REQ-033 Reset then release -> busy=1 for 32 cycles, rf_we=1 with rf_waddr 0..31 ascending, rf_wdata=0, then busy=0.
REQ-034 RUN, a_wreq only, addr 5, data 0xDEADBEEF -> a_wgnt same cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF.
REQ-035 Both requesters held 4 cycles (A addr 1, B addr 2) -> grants A,B,A,B; rf_waddr 1,2,1,2.
REQ-036 a_wreq addr 0 -> a_wgnt=1, rf_we stays 0; b_rreq addr 0 -> b_rvalid, b_rdata=0.
REQ-037 Write addr 7 = 0x12345678 granted, b_rreq addr 7 next cycle with rf_rdata=0 -> b_rdata=0x12345678 via bypass.
REQ-038 clr_req with both writes pending -> no grants that cycle, 32-cycle sweep, clr_req mid-sweep ignored; reset pulse mid-sweep -> sweep restarts at 0.
